// File: rtl/alu_exec_stage.sv
// Execute stage around a combinational 16-bit ALU: latches one op, captures result and {Z,N,C,V}.
// Optional ALU_EXEC_ACC_EN adds in_acc_sel and an accumulator that can stand in for operand A.
module alu_exec_stage #(
   parameter int DST_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
`ifdef ALU_EXEC_ACC_EN
   input  logic             in_acc_sel,
`endif
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic [DST_W-1:0] in_dst,
   output logic [2:0]       alu_op,
   output logic [15:0]      alu_in0,
   output logic [15:0]      alu_in1,
   input  logic [15:0]      alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      res_data,
   output logic [DST_W-1:0] res_dst,
   output logic [3:0]       res_flags
);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t           state_reg, state_next;
   logic [2:0]       op_reg;
   logic [15:0]      a_reg, b_reg;
   logic [DST_W-1:0] dst_reg;
   logic             accept;
   logic [15:0]      a_sel;
   logic [15:0]      add_sum;
   logic             c_flag, v_flag;
   logic [3:0]       flags_next;

`ifdef ALU_EXEC_ACC_EN
   logic [15:0] acc_reg;
   assign a_sel = in_acc_sel ? acc_reg : in_a;
`else
   assign a_sel = in_a;
`endif

   assign alu_op  = op_reg;
   assign alu_in0 = a_reg;
   assign alu_in1 = b_reg;

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = EXEC;
         end
         EXEC: state_next = HOLD;
         HOLD: begin
            // Retiring and accepting on the same edge keeps the 2-cycle cadence.
            in_ready = res_ready;
            if (res_ready) state_next = in_valid ? EXEC : IDLE;
         end
         default: state_next = IDLE;
      endcase
      accept = in_valid & in_ready;
   end

   // Unsigned add overflow shows up as a wrapped sum smaller than an addend.
   assign add_sum = a_reg + b_reg;

   always_comb begin
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (op_reg)
         OP_ADD: begin
            c_flag = (add_sum < a_reg);
            v_flag = (a_reg[15] == b_reg[15]) && (alu_out[15] != a_reg[15]);
         end
         OP_SUB: begin
            c_flag = (a_reg < b_reg);
            v_flag = (a_reg[15] != b_reg[15]) && (alu_out[15] != a_reg[15]);
         end
         default: ;
      endcase
      flags_next = {(alu_out == 16'h0000), alu_out[15], c_flag, v_flag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         dst_reg   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_dst   <= '0;
         res_flags <= '0;
`ifdef ALU_EXEC_ACC_EN
         acc_reg   <= '0;
`endif
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg  <= in_op;
            a_reg   <= a_sel;
            b_reg   <= in_b;
            dst_reg <= in_dst;
         end
         if (state_reg == EXEC) begin
            res_data  <= alu_out;
            res_dst   <= dst_reg;
            res_flags <= flags_next;
            res_valid <= 1'b1;
`ifdef ALU_EXEC_ACC_EN
            acc_reg   <= alu_out;
`endif
         end else if (state_reg == HOLD && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: a behavioural ALU drives alu_out, an arithmetic model predicts results.
// Build with +define+ALU_EXEC_ACC_EN to exercise the accumulator option.
module tb_alu_exec_stage;
   localparam int DST_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_op = '0;
   logic             in_acc_sel = 1'b0;
   logic [15:0]      in_a = '0, in_b = '0;
   logic [DST_W-1:0] in_dst = '0;
   logic [2:0]       alu_op;
   logic [15:0]      alu_in0, alu_in1, alu_out;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [15:0]      res_data;
   logic [DST_W-1:0] res_dst;
   logic [3:0]       res_flags;

   always #5 clk = ~clk;

   alu_exec_stage #(.DST_W(DST_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
`ifdef ALU_EXEC_ACC_EN
      .in_acc_sel(in_acc_sel),
`endif
      .in_a(in_a), .in_b(in_b), .in_dst(in_dst),
      .alu_op(alu_op), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out(alu_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_dst(res_dst), .res_flags(res_flags)
   );

   function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
      case (op)
         3'd1: return x + y;
         3'd2: return x - y;
         3'd3: return ~x;
         3'd4: return x & y;
         3'd5: return x | y;
         3'd6: return x ^ y;
         3'd7: return ~(x ^ y);
         default: return 16'h0000;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_op, alu_in0, alu_in1);

   typedef struct packed {
      logic [15:0]      data;
      logic [DST_W-1:0] dst;
      logic [3:0]       flags;
   } res_t;

   res_t sb[$];
   int   checks = 0;
   int   passes = 0;
   logic [15:0] acc_m = '0;

   // Reference: integer arithmetic, carry/overflow from value ranges rather than bit tricks.
   function automatic res_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [DST_W-1:0] dst);
      res_t r;
      int ua = int'(a), ub = int'(b);
      int sa = int'($signed(a)), sbv = int'($signed(b));
      int t = 0;
      bit c = 0, v = 0;
      logic [15:0] d;
      case (op)
         3'd1: begin t = ua + ub; c = (t > 65535); v = (sa + sbv > 32767) || (sa + sbv < -32768); end
         3'd2: begin t = ua - ub; c = (ua < ub);   v = (sa - sbv > 32767) || (sa - sbv < -32768); end
         3'd3: t = 65535 - ua;
         3'd4: t = int'(a & b);
         3'd5: t = int'(a | b);
         3'd6: t = int'(a ^ b);
         3'd7: t = 65535 - int'(a ^ b);
         default: t = 0;
      endcase
      d = t[15:0];
      r.data  = d;
      r.dst   = dst;
      r.flags = {d == 16'h0000, d >= 16'h8000, c, v};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Accept tracker: pushes expectations and checks the EXEC cycle and result latency.
   int exec_pending = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         exec_pending = 0;
         acc_m = '0;
      end else begin
         if (exec_pending == 2) begin
            chk("latency_res_valid", 32'(res_valid), 32'd1);
            exec_pending = 0;
         end
         if (exec_pending == 1) begin
            chk("exec_in_ready", 32'(in_ready), 32'd0);
            chk("exec_res_valid", 32'(res_valid), 32'd0);
            exec_pending = 2;
         end
         if (in_valid && in_ready) begin
            logic [15:0] eff_a;
            res_t e;
            eff_a = in_a;
`ifdef ALU_EXEC_ACC_EN
            if (in_acc_sel) eff_a = acc_m;
`endif
            e = model(in_op, eff_a, in_b, in_dst);
            acc_m = e.data;
            sb.push_back(e);
            exec_pending = 1;
         end
      end
   end

   // Monitor: compares each retired result and checks stability while stalled.
   res_t prev;
   bit   prev_stall = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         if (prev_stall)
            chk("hold_stable", 32'({res_valid, res_data, res_dst, res_flags}), 32'({1'b1, prev}));
         if (res_valid && !res_ready) begin
            chk("hold_in_ready_stall", 32'(in_ready), 32'd0);
            prev = {res_data, res_dst, res_flags};
            prev_stall = 1;
         end else begin
            prev_stall = 0;
         end
         if (res_valid && res_ready) begin
            chk("hold_in_ready_pass", 32'(in_ready), 32'd1);
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_result: got data %h with no pending op", res_data);
            end else begin
               res_t e;
               e = sb.pop_front();
               chk("res_data", 32'(res_data), 32'(e.data));
               chk("res_dst", 32'(res_dst), 32'(e.dst));
               chk("res_flags", 32'(res_flags), 32'(e.flags));
            end
         end
      end
   end

   bit rr_random = 0;
   bit rr_force  = 1;
   always @(posedge clk) begin
      #1;
      res_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_force;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [DST_W-1:0] dst, input logic sel);
      int n = 0;
      in_op = op; in_a = a; in_b = b; in_dst = dst; in_acc_sel = sel;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
   endtask

   function automatic logic [15:0] pick_operand();
      logic [15:0] edges [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'hAAAA};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      return 16'($urandom);
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_dst", 32'(res_dst), 32'd0);
      chk("rst_res_flags", 32'(res_flags), 32'd0);
      chk("rst_alu_drive", 32'({alu_op, alu_in0}), 32'd0);
      chk("rst_alu_in1", 32'(alu_in1), 32'd0);
      rst_n = 1'b1;
      idle(2);

      send(3'd1, 16'h7FFF, 16'h0001, 3'd1, 1'b0);
      send(3'd2, 16'h0003, 16'h0005, 3'd2, 1'b0);
      send(3'd1, 16'hFFFF, 16'h0001, 3'd3, 1'b0);
      send(3'd7, 16'hAAAA, 16'h5555, 3'd4, 1'b0);
      send(3'd0, 16'h1234, 16'h5678, 3'd5, 1'b0);
      idle(4);

      // Backpressure: first result stalls while the second op waits upstream.
      rr_force = 0;
      idle(1);
      send(3'd1, 16'h0100, 16'h0200, 3'd6, 1'b0);
      fork
         send(3'd6, 16'hF0F0, 16'h0FF0, 3'd7, 1'b0);
      join_none
      idle(4);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      rr_force = 1;
      wait fork;
      idle(4);

      // Reset during EXEC discards the op.
      send(3'd1, 16'h1234, 16'h1111, 3'd2, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_outputs", 32'({res_data, res_dst, res_flags}), 32'd0);
      chk("midrst_alu_drive", 32'({alu_op, alu_in0}), 32'd0);
      sb.delete();
      idle(2);
      rst_n = 1'b1;
      idle(6);
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      chk("postrst_res_valid", 32'(res_valid), 32'd0);

`ifdef ALU_EXEC_ACC_EN
      send(3'd1, 16'h0005, 16'h0000, 3'd1, 1'b0);
      send(3'd1, 16'hDEAD, 16'h0003, 3'd2, 1'b1);
      idle(4);
`endif

      rr_random = 1;
      for (int i = 0; i < 200; i++) begin
         send(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), DST_W'($urandom),
              1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      rr_random = 0;
      rr_force  = 1;
      begin
         int n = 0;
         while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
         end
         if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
         end
      end
      idle(2);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
